// File: rtl/amm_conduit_master.sv
// Avalon-MM master driven from board switches and a pushbutton.
// An address-phase press latches the switch value as the target word address.
// An execute-phase press issues one write of the switch value, or one read
// from that address. The bus status is mirrored on debug_flag.
module amm_conduit_master #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rdwr_cntl,
  input  logic        n_action,
  input  logic        add_data_sel,
  input  logic [31:0] rdwr_address,
  output logic [31:0] display_data,
  output logic [15:0] debug_flag,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_act_sync;
  logic [SYNC_STAGES-1:0] r_rw_sync;
  logic [SYNC_STAGES-1:0] r_sel_sync;
  logic                   w_act;
  logic                   w_rw;
  logic                   w_sel;

  logic                   r_db_level;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_press;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [31:0]            r_addr;
  logic [31:0]            w_addr_nxt;
  logic [31:0]            r_rd;
  logic [31:0]            w_rd_nxt;
  logic [31:0]            r_wdata;
  logic [31:0]            w_wdata_nxt;
  logic                   r_write;
  logic                   w_write_nxt;
  logic                   r_read;
  logic                   w_read_nxt;
  logic [TO_W-1:0]        r_tmo_cnt;
  logic [TO_W-1:0]        w_tmo_cnt_nxt;
  logic                   r_tmo_flag;
  logic                   w_tmo_flag_nxt;
  logic [3:0]             r_err_cnt;
  logic [3:0]             w_err_cnt_nxt;
  logic [7:0]             r_txn_cnt;
  logic [7:0]             w_txn_cnt_nxt;
  logic                   w_tmo_hit;

  // Input synchronizers; the button chain resets to its released (high) level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_sync <= '1;
      r_rw_sync  <= '0;
      r_sel_sync <= '0;
    end else begin
      r_act_sync <= SYNC_STAGES'({r_act_sync, n_action});
      r_rw_sync  <= SYNC_STAGES'({r_rw_sync, rdwr_cntl});
      r_sel_sync <= SYNC_STAGES'({r_sel_sync, add_data_sel});
    end
  end

  assign w_act = r_act_sync[SYNC_STAGES-1];
  assign w_rw  = r_rw_sync[SYNC_STAGES-1];
  assign w_sel = r_sel_sync[SYNC_STAGES-1];

  // Debounce: accept a new button level after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_level <= 1'b1;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (w_act == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_MAX) begin
        r_db_level <= w_act;
        r_db_cnt   <= '0;
        r_press    <= ~w_act;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // Transaction state and bus registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rd       <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_read     <= 1'b0;
      r_tmo_cnt  <= '0;
      r_tmo_flag <= 1'b0;
      r_err_cnt  <= '0;
      r_txn_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_rd       <= w_rd_nxt;
      r_wdata    <= w_wdata_nxt;
      r_write    <= w_write_nxt;
      r_read     <= w_read_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_tmo_flag <= w_tmo_flag_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_txn_cnt  <= w_txn_cnt_nxt;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt >= TO_MAX);

  // Next-state and next-register values; completion wins over timeout in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_rd_nxt       = r_rd;
    w_wdata_nxt    = r_wdata;
    w_write_nxt    = r_write;
    w_read_nxt     = r_read;
    w_tmo_cnt_nxt  = r_tmo_cnt + TO_W'(1);
    w_tmo_flag_nxt = r_tmo_flag;
    w_err_cnt_nxt  = r_err_cnt;
    w_txn_cnt_nxt  = r_txn_cnt;

    case (r_state)
      ST_IDLE: begin
        w_tmo_cnt_nxt = '0;
        w_write_nxt   = 1'b0;
        w_read_nxt    = 1'b0;
        if (r_press) begin
          if (w_sel) begin
            w_addr_nxt = {rdwr_address[31:2], 2'b00};
          end else if (w_rw) begin
            w_state_nxt = ST_READ;
            w_read_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_WRITE;
            w_write_nxt = 1'b1;
            w_wdata_nxt = rdwr_address;
          end
        end
      end

      ST_WRITE: begin
        if (!avm_waitrequest) begin
          w_state_nxt   = ST_IDLE;
          w_write_nxt   = 1'b0;
          w_txn_cnt_nxt = r_txn_cnt + 8'd1;
        end else if (w_tmo_hit) begin
          w_state_nxt    = ST_IDLE;
          w_write_nxt    = 1'b0;
          w_tmo_flag_nxt = 1'b1;
          w_err_cnt_nxt  = (r_err_cnt == 4'hF) ? 4'hF : r_err_cnt + 4'd1;
        end
      end

      ST_READ: begin
        if (!avm_waitrequest) begin
          w_read_nxt = 1'b0;
          if (avm_readdatavalid) begin
            w_state_nxt   = ST_IDLE;
            w_rd_nxt      = avm_readdata;
            w_txn_cnt_nxt = r_txn_cnt + 8'd1;
          end else begin
            w_state_nxt = ST_RD_WAIT;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt    = ST_IDLE;
          w_read_nxt     = 1'b0;
          w_tmo_flag_nxt = 1'b1;
          w_err_cnt_nxt  = (r_err_cnt == 4'hF) ? 4'hF : r_err_cnt + 4'd1;
        end
      end

      ST_RD_WAIT: begin
        w_read_nxt = 1'b0;
        if (avm_readdatavalid) begin
          w_state_nxt   = ST_IDLE;
          w_rd_nxt      = avm_readdata;
          w_txn_cnt_nxt = r_txn_cnt + 8'd1;
        end else if (w_tmo_hit) begin
          w_state_nxt    = ST_IDLE;
          w_tmo_flag_nxt = 1'b1;
          w_err_cnt_nxt  = (r_err_cnt == 4'hF) ? 4'hF : r_err_cnt + 4'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_write_nxt = 1'b0;
        w_read_nxt  = 1'b0;
      end
    endcase
  end

  assign avm_address    = r_addr;
  assign avm_read       = r_read;
  assign avm_write      = r_write;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = 4'hF;

  assign display_data = w_sel ? r_addr : r_rd;
  assign debug_flag   = {r_state, r_tmo_flag, (r_state != ST_IDLE), r_err_cnt, r_txn_cnt};

endmodule

// File: tb/tb_amm_conduit_master.sv
// Bench for amm_conduit_master: behavioural slave memory, button stimulus,
// scoreboard of expected bus requests and a reference model of the status.
module tb_amm_conduit_master;

  localparam int unsigned DBC = 4;
  localparam int unsigned TMO = 20;

  logic        clk;
  logic        reset_n;
  logic        rdwr_cntl;
  logic        n_action;
  logic        add_data_sel;
  logic [31:0] rdwr_address;
  logic [31:0] display_data;
  logic [15:0] debug_flag;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  amm_conduit_master #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(DBC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rdwr_cntl        (rdwr_cntl),
    .n_action         (n_action),
    .add_data_sel     (add_data_sel),
    .rdwr_address     (rdwr_address),
    .display_data     (display_data),
    .debug_flag       (debug_flag),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest  (avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
  } req_t;

  req_t exp_q[$];

  // slave configuration and state
  int  cfg_wait  = 0;
  int  cfg_lat   = 0;
  bit  cfg_stuck = 1'b0;
  int  s_pend    = 0;
  int  s_wait    = 0;
  bit  s_busy    = 1'b0;
  logic [31:0] s_pend_addr;
  logic [31:0] smem [logic [31:0]];

  // reference model
  logic [31:0] m_addr = '0;
  logic [31:0] m_rd   = '0;
  logic [7:0]  m_txn  = '0;
  int          m_err  = 0;
  bit          m_tmo  = 1'b0;
  logic [31:0] mmem [logic [31:0]];

  function automatic logic [31:0] fill(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Avalon slave: programmable wait states, read latency, or a stuck waitrequest.
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (!reset_n) begin
        s_busy = 1'b0;
        s_pend = 0;
        avm_waitrequest = 1'b0;
      end else begin
        if (s_pend > 0) begin
          s_pend--;
          if (s_pend == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = smem.exists(s_pend_addr) ? smem[s_pend_addr] : fill(s_pend_addr);
          end
        end
        if (avm_read || avm_write) begin
          if (!s_busy) begin
            s_busy = 1'b1;
            s_wait = cfg_wait;
          end
          if (cfg_stuck || s_wait > 0) begin
            avm_waitrequest = 1'b1;
            if (s_wait > 0) s_wait--;
          end else begin
            avm_waitrequest = 1'b0;
            s_busy = 1'b0;
            if (avm_write) begin
              smem[avm_address] = avm_writedata;
            end else if (cfg_lat == 0) begin
              avm_readdatavalid = 1'b1;
              avm_readdata = smem.exists(avm_address) ? smem[avm_address] : fill(avm_address);
            end else begin
              s_pend      = cfg_lat;
              s_pend_addr = avm_address;
            end
          end
        end else begin
          avm_waitrequest = 1'b0;
          s_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: pop an expected request whenever the DUT raises read/write.
  initial begin
    bit          act_prev;
    bit          cur_ok;
    req_t        cur;
    int          len;
    logic [31:0] a0;
    logic [31:0] d0;
    act_prev = 1'b0;
    cur_ok   = 1'b0;
    len      = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        act_prev = 1'b0;
        cur_ok   = 1'b0;
      end else begin
        if ((avm_read || avm_write) && !act_prev) begin
          len = 1;
          a0  = avm_address;
          d0  = avm_writedata;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            cur_ok = 1'b0;
            $display("FAIL unexpected_request: got rd=%0b wr=%0b addr=%h want no request",
                     avm_read, avm_write, avm_address);
          end else begin
            cur    = exp_q.pop_front();
            cur_ok = 1'b1;
            check("req_write_flag", 32'(avm_write), 32'(cur.is_wr));
            check("req_read_flag", 32'(avm_read), 32'(!cur.is_wr));
            check("req_addr", avm_address, cur.addr);
            if (cur.is_wr) check("req_wdata", avm_writedata, cur.data);
          end
        end else if ((avm_read || avm_write) && act_prev) begin
          len++;
          check("req_addr_stable", avm_address, a0);
          check("req_wdata_stable", avm_writedata, d0);
        end else if (!(avm_read || avm_write) && act_prev) begin
          if (cur_ok && cur.len > 0) check("req_length", 32'(len), 32'(cur.len));
          cur_ok = 1'b0;
        end
        act_prev = avm_read || avm_write;
      end
    end
  end

  task automatic press(input bit bounce);
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        n_action = (i % 2 == 0) ? 1'b0 : 1'b1;
        cyc(2);
      end
    end
    n_action = 1'b0;
    cyc(8);
    n_action = 1'b1;
    cyc(8);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((debug_flag[12] || s_pend > 0) && n < 200) begin
      cyc(1);
      n++;
    end
    check("idle_reached", 32'(debug_flag[12] || (s_pend > 0)), 32'd0);
  endtask

  task automatic check_state(input string tag);
    logic [15:0] e;
    e = {2'b00, m_tmo, 1'b0, 4'(m_err), m_txn};
    add_data_sel = 1'b1;
    cyc(3);
    check({tag, "_disp_addr"}, display_data, m_addr);
    add_data_sel = 1'b0;
    cyc(3);
    check({tag, "_disp_rd"}, display_data, m_rd);
    check({tag, "_debug"}, {16'h0, debug_flag}, {16'h0, e});
  endtask

  // Apply one operation to the model, queue the expected request, then press.
  task automatic do_op(input string tag, input bit sel, input bit rw, input logic [31:0] sw,
                       input int wt, input int lat, input bit stuck, input bit bounce);
    req_t r;
    bit   tmo;
    add_data_sel = sel;
    rdwr_cntl    = rw;
    rdwr_address = sw;
    cfg_wait     = wt;
    cfg_lat      = lat;
    cfg_stuck    = stuck;
    if (sel) begin
      m_addr = sw & 32'hFFFF_FFFC;
    end else begin
      tmo     = stuck || (rw && lat >= int'(TMO));
      r.is_wr = !rw;
      r.addr  = m_addr;
      r.data  = sw;
      r.len   = stuck ? int'(TMO) : wt + 1;
      exp_q.push_back(r);
      if (tmo) begin
        m_tmo = 1'b1;
        if (m_err < 15) m_err++;
      end else begin
        if (!rw) mmem[m_addr] = sw;
        else m_rd = mmem.exists(m_addr) ? mmem[m_addr] : fill(m_addr);
        m_txn = m_txn + 8'd1;
      end
    end
    cyc(4);
    press(bounce);
    wait_idle();
    check_state(tag);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got no finish want finish before 900us");
    $fatal(1);
  end

  initial begin
    bit          sel;
    bit          rw;
    bit          stuck;
    bit          bnc;
    int          wt;
    int          lat;
    logic [31:0] sw;
    req_t        r;
    int          n;

    reset_n      = 1'b0;
    n_action     = 1'b1;
    rdwr_cntl    = 1'b0;
    add_data_sel = 1'b0;
    rdwr_address = '0;
    #15;
    check("rst_display", display_data, 32'h0);
    check("rst_debug", {16'h0, debug_flag}, 32'h0);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_write", 32'(avm_write), 32'd0);
    check("rst_addr", avm_address, 32'h0);
    check("rst_wdata", avm_writedata, 32'h0);
    check("rst_byteenable", 32'(avm_byteenable), 32'hF);
    cyc(2);
    reset_n = 1'b1;
    cyc(4);

    do_op("addr_phase", 1'b1, 1'b0, 32'h0000_0107, 0, 0, 1'b0, 1'b0);
    do_op("addr_100", 1'b1, 1'b0, 32'h0000_0100, 0, 0, 1'b0, 1'b0);
    do_op("write_ws3", 1'b0, 1'b0, 32'hDEAD_BEEF, 3, 0, 1'b0, 1'b0);
    do_op("read_lat5", 1'b0, 1'b1, 32'h0000_0000, 0, 5, 1'b0, 1'b0);
    do_op("read_bounce", 1'b0, 1'b1, 32'h0000_0000, 1, 3, 1'b0, 1'b1);

    // second press lands while the read is waiting for its data
    add_data_sel = 1'b0;
    rdwr_cntl    = 1'b1;
    cfg_wait     = 0;
    cfg_lat      = 12;
    cfg_stuck    = 1'b0;
    r.is_wr = 1'b0;
    r.addr  = m_addr;
    r.data  = '0;
    r.len   = 1;
    exp_q.push_back(r);
    m_rd  = mmem.exists(m_addr) ? mmem[m_addr] : fill(m_addr);
    m_txn = m_txn + 8'd1;
    cyc(4);
    n_action = 1'b0;
    cyc(5);
    n_action = 1'b1;
    cyc(5);
    n_action = 1'b0;
    cyc(6);
    n_action = 1'b1;
    cyc(8);
    wait_idle();
    check_state("double_press");

    do_op("read_timeout", 1'b0, 1'b1, 32'h0, 0, 0, 1'b1, 1'b0);
    do_op("read_after_tmo", 1'b0, 1'b1, 32'h0, 2, 1, 1'b0, 1'b0);
    do_op("late_valid", 1'b0, 1'b1, 32'h0, 0, int'(TMO) + 4, 1'b0, 1'b0);
    do_op("read_same_cycle", 1'b0, 1'b1, 32'h0, 0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 400; k++) begin
      sel   = ($urandom_range(0, 3) == 0);
      rw    = 1'($urandom_range(0, 1));
      sw    = sel ? (32'h0000_1000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3)) : $urandom;
      wt    = $urandom_range(0, 3);
      lat   = $urandom_range(0, 8);
      stuck = ($urandom_range(0, 9) == 0);
      bnc   = ($urandom_range(0, 5) == 0);
      if (rw && $urandom_range(0, 14) == 0) lat = int'(TMO) + 4;
      do_op("rand", sel, rw, sw, wt, lat, stuck, bnc);
    end

    // asynchronous reset in the middle of a stalled read
    add_data_sel = 1'b0;
    rdwr_cntl    = 1'b1;
    cfg_stuck    = 1'b1;
    r.is_wr = 1'b0;
    r.addr  = m_addr;
    r.data  = '0;
    r.len   = 0;
    exp_q.push_back(r);
    cyc(4);
    n_action = 1'b0;
    n = 0;
    while (!avm_read && n < 30) begin
      cyc(1);
      n++;
    end
    check("mid_read_started", 32'(avm_read), 32'd1);
    cyc(2);
    n_action = 1'b1;
    reset_n  = 1'b0;
    #1;
    check("mid_rst_read", 32'(avm_read), 32'd0);
    check("mid_rst_write", 32'(avm_write), 32'd0);
    check("mid_rst_debug", {16'h0, debug_flag}, 32'h0);
    check("mid_rst_display", display_data, 32'h0);
    cfg_stuck = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
